// File: rtl/eth_rx_frame.sv
// Ethernet receive framer: finds preamble/SFD, checks CRC-32 and length, and streams
// the payload with the FCS stripped. Five bytes are held back so the FCS never leaves the block.
module eth_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int PRE_MIN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_d,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic        rx_en,
  output logic [7:0]  m_d,
  output logic        m_valid,
  output logic        m_last,
  output logic        stat_valid,
  output logic [3:0]  stat_err,
  output logic [10:0] stat_len
);
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [3:0]  PRE_L   = 4'(PRE_MIN);
  localparam logic [31:0] CRC_RES = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t           state_q, state_d;
  logic [3:0]       pre_cnt_q, pre_cnt_d;
  logic [31:0]      crc_q, crc_d;
  logic [10:0]      len_q, len_d, len_inc;
  logic [4:0][7:0]  hold_q, hold_d;
  logic [2:0]       hold_cnt_q, hold_cnt_d;
  logic             long_q, long_d, rxer_q, rxer_d;
  logic [7:0]       m_d_q, m_d_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic             stat_valid_q, stat_valid_d;
  logic [3:0]       stat_err_q, stat_err_d;
  logic [10:0]      stat_len_q, stat_len_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  assign len_inc = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    crc_d        = crc_q;
    len_d        = len_q;
    hold_d       = hold_q;
    hold_cnt_d   = hold_cnt_q;
    long_d       = long_q;
    rxer_d       = rxer_q;
    m_d_d        = 8'h00;
    m_valid_d    = 1'b0;
    m_last_d     = 1'b0;
    stat_valid_d = 1'b0;
    stat_err_d   = 4'h0;
    stat_len_d   = 11'h000;
    if (rx_en) begin
      case (state_q)
        IDLE: if (rx_dv) begin
          state_d   = (rx_d == 8'h55) ? PREAMBLE : DROP;
          pre_cnt_d = 4'd1;
        end
        PREAMBLE: begin
          if (!rx_dv) state_d = IDLE;
          else if (rx_d == 8'h55) begin
            if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
          end else if (rx_d == 8'hD5 && pre_cnt_q >= PRE_L) begin
            state_d    = DATA;
            crc_d      = 32'hFFFFFFFF;
            len_d      = 11'h000;
            hold_cnt_d = 3'd0;
            long_d     = 1'b0;
            rxer_d     = 1'b0;
          end else state_d = DROP;
        end
        DATA: begin
          if (rx_dv) begin
            crc_d  = crc_byte(crc_q, rx_d);
            len_d  = len_inc;
            hold_d = {rx_d, hold_q[4:1]};
            // Emission stops once an earlier byte already pushed the frame past MAX_LEN.
            if (hold_cnt_q == 3'd5) begin
              if (!long_q) begin
                m_valid_d = 1'b1;
                m_d_d     = hold_q[0];
              end
            end else hold_cnt_d = hold_cnt_q + 3'd1;
            if (len_inc > MAX_L) long_d = 1'b1;
            if (rx_er) rxer_d = 1'b1;
          end else begin
            state_d      = IDLE;
            stat_valid_d = 1'b1;
            stat_len_d   = len_q;
            stat_err_d   = {rxer_q, long_q, len_q < MIN_L, crc_q != CRC_RES};
            if (hold_cnt_q == 3'd5 && !long_q) begin
              m_valid_d = 1'b1;
              m_last_d  = 1'b1;
              m_d_d     = hold_q[0];
            end
          end
        end
        DROP: if (!rx_dv) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pre_cnt_q    <= 4'd0;
      crc_q        <= 32'hFFFFFFFF;
      len_q        <= 11'h000;
      hold_q       <= '0;
      hold_cnt_q   <= 3'd0;
      long_q       <= 1'b0;
      rxer_q       <= 1'b0;
      m_d_q        <= 8'h00;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_err_q   <= 4'h0;
      stat_len_q   <= 11'h000;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      hold_q       <= hold_d;
      hold_cnt_q   <= hold_cnt_d;
      long_q       <= long_d;
      rxer_q       <= rxer_d;
      m_d_q        <= m_d_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      stat_valid_q <= stat_valid_d;
      stat_err_q   <= stat_err_d;
      stat_len_q   <= stat_len_d;
    end
  end

  assign m_d        = m_d_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign stat_valid = stat_valid_q;
  assign stat_err   = stat_err_q;
  assign stat_len   = stat_len_q;
endmodule

// File: doc/eth_rx_frame.md
Name: eth_rx_frame

Overview:
- Ethernet frame receiver downstream of phy_100Mb's byte-wide receive side (rx_d/rx_dv/rx_er), operating in the system clk domain.
- Byte strobe rx_en arrives already synchronised to clk.
- Detects preamble/SFD and strips preamble, SFD and 4-byte FCS.
- Checks CRC-32 and length, then streams payload bytes out with an end-of-frame marker and a one-cycle status word.

Parameters:
- MIN_LEN, 64, minimum frame length in bytes after SFD, FCS included.
- MAX_LEN, 1518, maximum frame length in bytes after SFD, FCS included.
- PRE_MIN, 1, minimum number of 0x55 bytes required before the SFD.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- rx_d  input  8  received byte, valid when rx_en=1
- rx_dv  input  1  frame active level; sampled only when rx_en=1
- rx_er  input  1  PHY error flag for the current byte
- rx_en  input  1  one-cycle byte strobe
- m_d  output  8  payload byte
- m_valid  output  1  m_d valid, one cycle per byte
- m_last  output  1  qualifies the final payload byte of a frame
- stat_valid  output  1  one-cycle frame status strobe
- stat_err  output  4  bit0 CRC, bit1 short, bit2 long, bit3 rx_er seen
- stat_len  output  11  bytes after SFD including FCS, saturating at 2047

Behaviour:
- Reset: all outputs 0, state IDLE, CRC register 0xFFFFFFFF, length 0, hold buffer empty.
- Only cycles with rx_en=1 advance the FSM. A byte with rx_dv=0 marks end of frame; its data is ignored.
- IDLE:
  - rx_dv=1, rx_d=0x55: go to PREAMBLE, pre_cnt=1.
  - rx_dv=1, any other byte: go to DROP.
- PREAMBLE:
  - 0x55: pre_cnt++, saturating at 15.
  - 0xD5 with pre_cnt>=PRE_MIN: go to DATA; clear CRC, length, hold buffer and error flags.
  - Any other byte, or 0xD5 with pre_cnt<PRE_MIN: go to DROP.
  - rx_dv=0: go to IDLE with no status.
- DATA:
  - Each byte updates the CRC: reflected polynomial 0xEDB88320, LSB first, no final xor.
  - Length increments, saturating at 2047.
  - Byte is pushed into a 5-deep hold buffer. When a push finds 5 bytes already held, the oldest is emitted on m_d with m_valid=1 in the next cycle (latency 1 clk after the strobe).
  - When length exceeds MAX_LEN: set the long flag, stop emitting, keep counting.
  - rx_er=1 on any byte: set bit3.
- End of frame (rx_dv=0 strobe in DATA):
  - Next cycle: stat_valid=1 with stat_len and stat_err.
  - If the buffer holds 5 bytes and no long error, the same cycle also emits the oldest byte with m_valid=1 and m_last=1. The remaining 4 held bytes are FCS and are discarded.
  - CRC flag set unless the CRC register equals 0xDEBB20E3.
  - Short flag set if len<MIN_LEN.
  - Frames with len<=4 emit no payload and no m_last, status only.
  - Then go to IDLE.
- DROP: ignore bytes until an rx_dv=0 strobe, then go to IDLE. No status, no output.
- Payload already emitted is not retracted. Consumers must act on stat_err at m_last/stat_valid.
- No backpressure. m_valid is never asserted on two consecutive cycles without intervening strobes.
- rst mid-frame: outputs drop to 0 the same edge, no status. If rx_dv is still high, the next strobe sees IDLE with a non-0x55 byte and enters DROP.
- rx_en and rst together: rst wins, byte discarded.

Test Plan:
1. PRE_MIN=1, MIN_LEN=8. Send 7×0x55, 0xD5, 0x31..0x39 ("123456789"), FCS 0x26 0x39 0xF4 0xCB, then rx_dv=0 → m_d 0x31..0x39 with m_last on 0x39; stat_valid with stat_err=0, stat_len=13.
2. Same frame with FCS last byte 0xCA → identical payload stream; stat_err=4'b0001, stat_len=13.
3. MIN_LEN=64 with frame 1 → stat_err=4'b0010, stat_len=13; payload still emitted.
4. MAX_LEN=10 with frame 1 → payload stops after 6 bytes (0x31..0x36); no m_last; stat_err=4'b0100, stat_len=13.
5. Preamble 0x55, 0x55, 0xAA followed by frame-1 bytes, then rx_dv=0 → no m_valid, no stat_valid. A subsequent valid frame 1 decodes correctly.
6. rx_er=1 on byte 0x34 of frame 1 → stat_err=4'b1000. Separately, rst pulsed after 0x33 → outputs 0 with no status; next valid frame decodes with stat_err=0.
